aes_decipher_pipe: RTL and testbench

Fully pipelined AES inverse cipher: accepts one 128-bit ciphertext block per clock and returns the plaintext a fixed number of cycles later. It is the decrypt-direction counterpart of the pipelined encipher datapath and sits beside it in the AES datapath. It holds its own round-key file, loaded over a simple write port. Throughput is one block per cycle once keys are loaded.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_inv_sbox.sv | 22 ++
 rtl/aes_decipher_pipe.sv | 84 ++++++++
 tb/tb_aes_decipher_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers. The encipher datapath uses gm2 and the round counts.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES256_ROUNDS = 14;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    // One column, a0 in the top byte (row 0).
    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
                gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3),
                gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv_mixw(s[127-32*c -: 32]);
        return o;
    endfunction

    // Byte r+4c sits at s[127-8*(r+4c) -: 8]; row r moves right by r columns.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four parallel inverse S-box byte lookups over one 32-bit word.
module aes_inv_sbox (
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign w_o[8*b +: 8] = INV_SBOX[w_i[8*b +: 8]];
    end

endmodule

// File: rtl/aes_decipher_pipe.sv
// Fully pipelined AES inverse cipher, one block per clock, with a local round-key file.
// Any key write flushes every in-flight block; data registers free-run regardless of valid.
module aes_decipher_pipe
    import aes_pkg::*;
#(
    parameter int AES_ROUND_NUM = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_we,
    input  logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         key_ready,
    input  logic         in_valid,
    input  logic [127:0] block,
    output logic         out_valid,
    output logic [127:0] new_block
);

    localparam int NR = AES_ROUND_NUM;

    logic [NR:0][127:0] key_q;
    logic [NR:0]        mask_q, mask_d;
    logic               key_ready_q;
    logic [NR:0]        vld_pipe_q;
    logic [NR:0][127:0] stage_q, stage_d;
    logic               out_valid_q;
    logic [127:0]       new_block_q;
    logic               accept;

    assign accept = in_valid & key_ready_q & ~key_we;

    // Out-of-range indices match no slot, so they leave keys and mask untouched.
    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i <= NR; i++)
            if (key_we && key_idx == 4'(i)) mask_d[i] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q       <= '0;
            mask_q      <= '0;
            key_ready_q <= 1'b0;
            vld_pipe_q  <= '0;
            out_valid_q <= 1'b0;
            new_block_q <= '0;
        end else begin
            for (int i = 0; i <= NR; i++)
                if (key_we && key_idx == 4'(i)) key_q[i] <= round_key;
            mask_q      <= mask_d;
            key_ready_q <= &mask_d;
            vld_pipe_q  <= key_we ? '0 : {vld_pipe_q[NR-1:0], accept};
            // Gate the last stage too, so a block leaving at the key write is also killed.
            out_valid_q <= vld_pipe_q[NR] & ~key_we;
            new_block_q <= stage_q[NR];
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign stage_d[0] = block ^ key_q[NR];

    for (genvar i = 1; i <= NR; i++) begin : g_round
        logic [127:0] sr, sb, ark;
        assign sr = inv_shiftrows(stage_q[i-1]);
        for (genvar w = 0; w < 4; w++) begin : g_sbox
            aes_inv_sbox u_sbox (.w_i(sr[32*w +: 32]), .w_o(sb[32*w +: 32]));
        end
        assign ark = sb ^ key_q[NR-i];
        if (i == NR) begin : g_last
            assign stage_d[i] = ark;
        end else begin : g_mid
            assign stage_d[i] = inv_mixcolumns(ark);
        end
    end

    assign key_ready = key_ready_q;
    assign out_valid = out_valid_q;
    assign new_block = new_block_q;

endmodule

// File: tb/tb_aes_decipher_pipe.sv
// Directed bench for aes_decipher_pipe (AES-128 and AES-256 instances); expected plaintexts
// come from FIPS-197 vectors or from a forward-cipher model with its own key expansion.
module tb_aes_decipher_pipe;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         kwe, kwe_b, kready, kready_b, ivld, ivld_b, ovld, ovld_b;
    logic [3:0]   kidx, kidx_b;
    logic [127:0] rkey, rkey_b, blk, blk_b, nblk, nblk_b;

    int nvec = 0;
    int nerr = 0;

    logic [127:0] rk128 [0:10];
    logic [127:0] rk256 [0:14];

    logic [0:255][7:0] sbox_t = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_decipher_pipe #(.AES_ROUND_NUM(10)) dut (
        .clk(clk), .reset_n(reset_n), .key_we(kwe), .key_idx(kidx), .round_key(rkey),
        .key_ready(kready), .in_valid(ivld), .block(blk), .out_valid(ovld), .new_block(nblk));

    aes_decipher_pipe #(.AES_ROUND_NUM(14)) dut256 (
        .clk(clk), .reset_n(reset_n), .key_we(kwe_b), .key_idx(kidx_b), .round_key(rkey_b),
        .key_ready(kready_b), .in_valid(ivld_b), .block(blk_b), .out_valid(ovld_b),
        .new_block(nblk_b));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    // ---------------- forward-cipher reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_t[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ (nr == 10 ? rk128[0] : rk256[0]);
        for (int r = 1; r <= nr; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r != nr) s = mix_columns(s);
            s = s ^ (nr == 10 ? rk128[r] : rk256[r]);
        end
        return s;
    endfunction

    task automatic expand_key(input logic [255:0] k, input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 8) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_keys(input bit wide, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (wide) begin kwe_b = 1'b1; kidx_b = 4'(i); rkey_b = rk256[i]; end
            else      begin kwe   = 1'b1; kidx   = 4'(i); rkey   = rk128[i]; end
            tick();
        end
        kwe = 1'b0; kwe_b = 1'b0;
    endtask

    // Observes n cycles; first_at is the cycle index of the first out_valid seen.
    task automatic watch(input bit wide, input int n, output int pulses, output int first_at,
                         output logic [127:0] data);
        pulses = 0; first_at = -1; data = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (wide ? ovld_b : ovld) begin
                if (pulses == 0) begin first_at = k; data = wide ? nblk_b : nblk; end
                pulses++;
            end
        end
    endtask

    task automatic decrypt_one(input bit wide, input logic [127:0] ct, output int pulses,
                               output int lat, output logic [127:0] pt);
        if (wide) begin ivld_b = 1'b1; blk_b = ct; end
        else      begin ivld   = 1'b1; blk   = ct; end
        tick();
        ivld = 1'b0; ivld_b = 1'b0;
        watch(wide, 40, pulses, lat, pt);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        nvec++; if (kready !== 1'b0) begin nerr++; $display("FAIL rst_key_ready: got %b want 0", kready); end
        nvec++; if (ovld !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", ovld); end
        nvec++; if (nblk !== 128'h0) begin nerr++; $display("FAIL rst_new_block: got %h want 0", nblk); end
        nvec++; if (kready_b !== 1'b0) begin nerr++; $display("FAIL rst_key_ready_256: got %b want 0", kready_b); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fips128();
        int p, lat;
        logic [127:0] pt;
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        load_keys(0, 0, 10);
        nvec++; if (kready !== 1'b1) begin nerr++; $display("FAIL fipsb_key_ready: got %b want 1", kready); end
        decrypt_one(0, 128'h3925841d02dc09fbdc118597196a0b32, p, lat, pt);
        nvec++; if (pt !== 128'h3243f6a8885a308d313198a2e0370734) begin nerr++; $display("FAIL fipsb_pt: got %h want 3243f6a8885a308d313198a2e0370734", pt); end
        nvec++; if (lat !== 11) begin nerr++; $display("FAIL fipsb_latency: got %0d want 11", lat); end
        nvec++; if (p !== 1) begin nerr++; $display("FAIL fipsb_pulses: got %0d want 1", p); end
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        load_keys(0, 0, 10);
        decrypt_one(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, p, lat, pt);
        nvec++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin nerr++; $display("FAIL fipsc1_pt: got %h want 00112233445566778899aabbccddeeff", pt); end
        nvec++; if (lat !== 11) begin nerr++; $display("FAIL fipsc1_latency: got %0d want 11", lat); end
    endtask

    task automatic test_aes256();
        int p, lat;
        logic [127:0] pt;
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        load_keys(1, 0, 14);
        nvec++; if (kready_b !== 1'b1) begin nerr++; $display("FAIL c3_key_ready: got %b want 1", kready_b); end
        decrypt_one(1, 128'h8ea2b7ca516745bfeafc49904b496089, p, lat, pt);
        nvec++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin nerr++; $display("FAIL c3_pt: got %h want 00112233445566778899aabbccddeeff", pt); end
        nvec++; if (lat !== 15) begin nerr++; $display("FAIL c3_latency: got %0d want 15", lat); end
        nvec++; if (p !== 1) begin nerr++; $display("FAIL c3_pulses: got %0d want 1", p); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [64];
        logic [127:0] cts [64];
        int got, first, last;
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        load_keys(0, 0, 10);
        for (int j = 0; j < 64; j++) begin pts[j] = rnd128(); cts[j] = encrypt(pts[j], 10); end
        got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 64 + 30; cyc++) begin
            if (ovld) begin
                if (got < 64) begin
                    nvec++;
                    if (nblk !== pts[got]) begin nerr++; $display("FAIL b2b_pt[%0d]: got %h want %h", got, nblk, pts[got]); end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 64) begin ivld = 1'b1; blk = cts[cyc]; end
            else ivld = 1'b0;
            tick();
        end
        nvec++; if (got !== 64) begin nerr++; $display("FAIL b2b_count: got %0d want 64", got); end
        nvec++; if (first !== 12) begin nerr++; $display("FAIL b2b_first_cycle: got %0d want 12", first); end
        nvec++; if (last - first !== 63) begin nerr++; $display("FAIL b2b_span: got %0d want 63", last - first); end
    endtask

    task automatic test_partial_keys();
        int p, lat;
        logic [127:0] pt;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        load_keys(0, 0, 9);
        nvec++; if (kready !== 1'b0) begin nerr++; $display("FAIL partial_key_ready: got %b want 0", kready); end
        for (int j = 0; j < 3; j++) begin ivld = 1'b1; blk = 128'h3925841d02dc09fbdc118597196a0b32; tick(); end
        ivld = 1'b0;
        watch(0, 20, p, lat, pt);
        nvec++; if (p !== 0) begin nerr++; $display("FAIL partial_no_output: got %0d pulses want 0", p); end
        kwe = 1'b1; kidx = 4'd10; rkey = rk128[10];
        ivld = 1'b1; blk = 128'h3925841d02dc09fbdc118597196a0b32;
        tick();
        kwe = 1'b0; blk = encrypt(128'h00112233445566778899aabbccddeeff, 10);
        tick();
        ivld = 1'b0;
        nvec++; if (kready !== 1'b1) begin nerr++; $display("FAIL last_key_ready: got %b want 1", kready); end
        watch(0, 30, p, lat, pt);
        nvec++; if (p !== 1) begin nerr++; $display("FAIL last_key_pulses: got %0d want 1", p); end
        nvec++; if (lat !== 11) begin nerr++; $display("FAIL last_key_latency: got %0d want 11", lat); end
        nvec++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin nerr++; $display("FAIL last_key_pt: got %h want 00112233445566778899aabbccddeeff", pt); end
    endtask

    task automatic test_flush();
        int p, lat;
        logic [127:0] pt, ptn, newk;
        for (int j = 0; j < 5; j++) begin ivld = 1'b1; blk = encrypt(rnd128(), 10); tick(); end
        ivld = 1'b0;
        newk = rnd128();
        kwe = 1'b1; kidx = 4'd3; rkey = newk;
        tick();
        kwe = 1'b0;
        watch(0, 25, p, lat, pt);
        nvec++; if (p !== 0) begin nerr++; $display("FAIL flush_idx3_pulses: got %0d want 0", p); end
        nvec++; if (kready !== 1'b1) begin nerr++; $display("FAIL flush_idx3_key_ready: got %b want 1", kready); end
        rk128[3] = newk;
        ptn = rnd128();
        decrypt_one(0, encrypt(ptn, 10), p, lat, pt);
        nvec++; if (pt !== ptn) begin nerr++; $display("FAIL newkey_pt: got %h want %h", pt, ptn); end
        nvec++; if (lat !== 11) begin nerr++; $display("FAIL newkey_latency: got %0d want 11", lat); end
        for (int j = 0; j < 3; j++) begin ivld = 1'b1; blk = encrypt(rnd128(), 10); tick(); end
        ivld = 1'b0;
        kwe = 1'b1; kidx = 4'd15; rkey = rnd128();
        tick();
        kwe = 1'b0;
        watch(0, 25, p, lat, pt);
        nvec++; if (p !== 0) begin nerr++; $display("FAIL flush_idx15_pulses: got %0d want 0", p); end
        nvec++; if (kready !== 1'b1) begin nerr++; $display("FAIL flush_idx15_key_ready: got %b want 1", kready); end
        ptn = rnd128();
        decrypt_one(0, encrypt(ptn, 10), p, lat, pt);
        nvec++; if (pt !== ptn) begin nerr++; $display("FAIL idx15_keys_kept_pt: got %h want %h", pt, ptn); end
    endtask

    task automatic test_reset_midstream();
        int p, lat, k;
        logic [127:0] pt;
        for (int j = 0; j < 6; j++) begin ivld = 1'b1; blk = encrypt(rnd128(), 10); tick(); end
        ivld = 1'b0;
        k = 0;
        while (!ovld && k < 20) begin tick(); k++; end
        nvec++; if (ovld !== 1'b1) begin nerr++; $display("FAIL midrst_stream_live: got %b want 1", ovld); end
        reset_n = 1'b0;
        #1;
        nvec++; if (ovld !== 1'b0) begin nerr++; $display("FAIL midrst_out_valid: got %b want 0", ovld); end
        nvec++; if (kready !== 1'b0) begin nerr++; $display("FAIL midrst_key_ready: got %b want 0", kready); end
        nvec++; if (nblk !== 128'h0) begin nerr++; $display("FAIL midrst_new_block: got %h want 0", nblk); end
        tick(); tick();
        reset_n = 1'b1;
        ivld = 1'b1; blk = 128'h3925841d02dc09fbdc118597196a0b32;
        watch(0, 25, p, lat, pt);
        ivld = 1'b0;
        nvec++; if (p !== 0) begin nerr++; $display("FAIL midrst_no_stale: got %0d pulses want 0", p); end
        nvec++; if (kready !== 1'b0) begin nerr++; $display("FAIL midrst_keys_cleared: got %b want 0", kready); end
    endtask

    initial begin
        reset_n = 1'b0;
        kwe = 1'b0; kidx = '0; rkey = '0; ivld = 1'b0; blk = '0;
        kwe_b = 1'b0; kidx_b = '0; rkey_b = '0; ivld_b = 1'b0; blk_b = '0;
        test_reset();
        test_fips128();
        test_aes256();
        test_back_to_back();
        test_partial_keys();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
